mem_request_responder: RTL
==========================

Name: mem_request_responder

Overview:
- Services the instruction-fetch and data-memory requests produced by the single-cycle control unit: cu_imemREN, cu_dmemREN, cu_dmemWEN, dmemaddr and dmemstore.
- Arbitrates them onto one single-ported RAM with variable latency.
- Returns registered ihit/dhit pulses with load data.
- Tracks per-instruction data-access completion so a held data request is served exactly once before the fetch that advances PC.

Parameters:
WORD_W, 32, width of addresses and data words
WAIT_LIMIT, 255, max cycles to wait for ram_ready before flagging timeout (range 1..65535)

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
cu_imemREN  input  1  instruction fetch request
imemaddr  input  WORD_W  fetch address (PC)
cu_dmemREN  input  1  data read request, held combinationally by the control unit
cu_dmemWEN  input  1  data write request
dmemaddr  input  WORD_W  data address
dmemstore  input  WORD_W  write data
halt  input  1  halt from the control unit
ihit  output  1  one-cycle pulse: fetch complete, imemload valid
dhit  output  1  one-cycle pulse: data access complete
imemload  output  WORD_W  fetched instruction, held
dmemload  output  WORD_W  read data, held
ramREN  output  1  RAM read enable
ramWEN  output  1  RAM write enable
ramaddr  output  WORD_W  RAM address
ramstore  output  WORD_W  RAM write data
ramload  input  WORD_W  RAM read data, valid when ram_ready=1
ram_ready  input  1  RAM access completes this cycle
halted  output  1  sticky: halted or timed out
timeout  output  1  sticky: RAM timeout occurred

Behaviour:
- Reset (nRST=0, async):
  - state=IDLE; dserved=0; wait counter=0.
  - ihit, dhit, ramREN, ramWEN, halted and timeout are all 0.
  - imemload, dmemload, ramaddr and ramstore are all 0.
  - Reset mid-access abandons the access immediately; RAM enables drop asynchronously.
- States: IDLE, DATA, INSTR, HALTED.
- IDLE, evaluated in priority order each edge:
  - Data request pending ((cu_dmemREN|cu_dmemWEN) and !dserved): capture dmemaddr, dmemstore and the write flag, then go to DATA. Write has priority if both REN and WEN are high.
  - Otherwise, if halt=1: go to HALTED.
  - Otherwise, if cu_imemREN: capture imemaddr, then go to INSTR.
  - Otherwise: stay in IDLE.
- IDLE outputs: RAM enables are 0, and ram_ready is ignored.
- DATA:
  - ramaddr and ramstore come from the captured registers.
  - ramWEN=captured write flag; ramREN=!write flag.
  - Inputs changing mid-access have no effect.
- INSTR:
  - ramREN=1, ramWEN=0, ramaddr=captured fetch address.
- Completion, on an edge where state is DATA/INSTR and ram_ready=1:
  - Return to IDLE.
  - For a read, dmemload or imemload is loaded from ramload.
  - dhit or ihit goes high for exactly the next cycle.
  - A data completion sets dserved=1; an instruction completion clears dserved.
- Back-to-back: the cycle after completion is IDLE, so the minimum access is 2 cycles (issue plus ready).
- Write completion leaves dmemload unchanged.
- Wait counter:
  - Resets to 0 on entry to DATA or INSTR.
  - Increments each cycle with ram_ready=0.
  - If it reaches WAIT_LIMIT without ram_ready: set timeout=1 and go to HALTED, with no hit.
  - Saturating; width is ceil(log2(WAIT_LIMIT+1)).
- HALTED: absorbing until reset; halted=1, all enables 0, no hits, ram_ready ignored.
- Halt only takes effect from IDLE with no pending unserved data request, so a halt issued during an access waits for that access to finish.
- ihit and dhit are never high in the same cycle.

Test Plan:
- Reset, then cu_imemREN=1, imemaddr=0x0000_0010; RAM returns 0x3C01_1234 with ram_ready after 3 wait cycles -> ramREN high for 4 cycles, addr 0x10; ihit pulses 1 cycle; imemload=0x3C01_1234; dhit never asserted.
- LW: cu_dmemREN=1, dmemaddr=0x80, cu_imemREN=1, held until ihit; RAM 1-cycle ready, data 0xDEAD_BEEF -> data access first (dhit, dmemload=0xDEADBEEF), then fetch at PC (ihit); no second read of 0x80; dserved clears after ihit.
- SW: cu_dmemWEN=1 and cu_dmemREN=1 both asserted, dmemaddr=0x100, dmemstore=0xCAFE_F00D -> ramWEN=1, ramREN=0, ramstore=0xCAFEF00D; dhit pulses; dmemload unchanged.
- halt=1 while an INSTR access is pending, ready after 2 cycles -> fetch completes with ihit, then HALTED; halted=1; RAM enables stay 0 with requests still asserted.
- WAIT_LIMIT=4, fetch with ram_ready held 0 -> timeout=1 and halted=1 after 4 wait cycles; no ihit; a later ram_ready is ignored.
- Assert nRST=0 mid-DATA access (ramREN=1) -> ramREN=0 immediately, all outputs 0; after release a new fetch proceeds normally.

Source files
------------

// File: rtl/mem_request_responder.sv
// Arbitrates control-unit fetch and data requests onto one variable-latency RAM port.
// Latency: issue cycle plus RAM wait cycles; ihit/dhit are registered one cycle after ram_ready.
// Backpressure: requests are held by the control unit until the matching hit; a stalled RAM times out to HALTED.
module mem_request_responder #(
    parameter int WORD_W     = 32,
    parameter int WAIT_LIMIT = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              cu_imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    input  logic              cu_dmemREN,
    input  logic              cu_dmemWEN,
    input  logic [WORD_W-1:0] dmemaddr,
    input  logic [WORD_W-1:0] dmemstore,
    input  logic              halt,
    output logic              ihit,
    output logic              dhit,
    output logic [WORD_W-1:0] imemload,
    output logic [WORD_W-1:0] dmemload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ram_ready,
    output logic              halted,
    output logic              timeout
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

    typedef enum logic [1:0] {IDLE, DATA, INSTR, HALTED} state_t;

    state_t            state, state_nxt;
    logic [WORD_W-1:0] addr_q, store_q;
    logic              wr_q;
    logic              dserved;
    logic [CW-1:0]     wait_cnt, cnt_inc;
    logic              cap_d, cap_i, done, tmo, busy;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cap_d     = 1'b0;
        cap_i     = 1'b0;
        done      = 1'b0;
        tmo       = 1'b0;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        busy      = 1'b0;
        cnt_inc   = (wait_cnt == {CW{1'b1}}) ? wait_cnt : wait_cnt + CW'(1);
        case (state)
            IDLE: begin
                // A held data request wins once per instruction; dserved masks it until the next fetch.
                if ((cu_dmemREN || cu_dmemWEN) && !dserved) begin
                    cap_d     = 1'b1;
                    state_nxt = DATA;
                end else if (halt) begin
                    state_nxt = HALTED;
                end else if (cu_imemREN) begin
                    cap_i     = 1'b1;
                    state_nxt = INSTR;
                end
            end
            DATA, INSTR: begin
                busy   = 1'b1;
                ramWEN = (state == DATA) && wr_q;
                ramREN = (state == INSTR) || !wr_q;
                if (ram_ready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt_inc == LIMIT) begin
                    tmo       = 1'b1;
                    state_nxt = HALTED;
                end
            end
            HALTED: state_nxt = HALTED;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            addr_q   <= '0;
            store_q  <= '0;
            wr_q     <= 1'b0;
            dserved  <= 1'b0;
            wait_cnt <= '0;
            ihit     <= 1'b0;
            dhit     <= 1'b0;
            imemload <= '0;
            dmemload <= '0;
            timeout  <= 1'b0;
        end else begin
            ihit <= 1'b0;
            dhit <= 1'b0;
            if (cap_d) begin
                addr_q   <= dmemaddr;
                store_q  <= dmemstore;
                wr_q     <= cu_dmemWEN;
                wait_cnt <= '0;
            end else if (cap_i) begin
                addr_q   <= imemaddr;
                wait_cnt <= '0;
            end else if (busy && !ram_ready) begin
                wait_cnt <= cnt_inc;
            end
            if (done) begin
                if (state == DATA) begin
                    dhit    <= 1'b1;
                    dserved <= 1'b1;
                    if (!wr_q) begin
                        dmemload <= ramload;
                    end
                end else begin
                    ihit     <= 1'b1;
                    dserved  <= 1'b0;
                    imemload <= ramload;
                end
            end
            if (tmo) begin
                timeout <= 1'b1;
            end
        end
    end

    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign halted   = (state == HALTED);

endmodule
